// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting beside data RAM on the core's data port.
// Latency: a TXDATA store at edge E into an idle, empty block drives the start bit from edge E+1; a frame is 10*max(BAUDDIV,1) cycles.
// Backpressure: none toward the core; a store to a full FIFO drops the byte and sets the sticky overflow flag.
//
// Ports:
//   clk, reset       system clock; asynchronous active-low reset
//   MemWrite         one-cycle store strobe from the core
//   Adr, WriteData   byte address and store data from the core
//   Sel              combinational window hit (Adr[31:4] == BASE_ADDR[31:4]), steers the system read mux
//   RdData           combinational register readback for Adr, zero when Sel is low
//   tx               serial line, idles high
//   irq              registered "transmit done": FIFO empty and transmitter idle
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic        Sel,
    output logic [31:0] RdData,
    output logic        tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Register offsets within the 16-byte window (Adr[3:2]).
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          overflow;
    logic [15:0]   bauddiv;

    state_t        state;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [1:0]    reg_idx;
    logic          wr_en;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          bit_done;
    logic [15:0]   div_m1;
    logic          idle_nxt;
    logic          unused_bits;

    // Byte lanes and the upper half of WriteData carry nothing this block needs.
    assign unused_bits = ^{WriteData[31:16], Adr[1:0]};

    assign Sel     = (Adr[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = MemWrite && Sel;
    assign reg_idx = Adr[3:2];
    assign push    = wr_en && (reg_idx == REG_TXDATA);

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != S_IDLE);
    assign bit_done = (bit_cnt == 16'd0);

    // Bit counter reload value; a divider of 0 behaves as 1.
    assign div_m1 = (bauddiv == 16'd0) ? 16'd0 : (bauddiv - 16'd1);

    // The FSM takes a byte either from IDLE or at the end of a STOP bit.
    assign pop = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));

    // When full, a simultaneous pop frees the slot first so the push lands.
    assign push_ok = push && (!full || pop);

    assign idle_nxt = ((state == S_IDLE) && !pop) ||
                      ((state == S_STOP) && bit_done && !pop);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO storage needs no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bauddiv  <= DEFAULT_DIV;
        end else begin
            count <= count_nxt;
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr_en && (reg_idx == REG_STATUS) && WriteData[3]) begin
                overflow <= 1'b0;
            end
            if (wr_en && (reg_idx == REG_BAUDDIV)) begin
                bauddiv <= WriteData[15:0];
            end
        end
    end

    // Transmit FSM. bit_cnt counts down the cycles left in the current bit and
    // is reloaded from BAUDDIV at every bit boundary, so a divider change
    // applies from the next bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            irq     <= 1'b1;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else begin
            irq <= (count_nxt == '0) && idle_nxt;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_mem[rptr];
                        state   <= S_START;
                        tx      <= 1'b0;
                        bit_cnt <= div_m1;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        tx      <= shift[0];
                        bit_cnt <= div_m1;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        bit_cnt <= div_m1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            // Next byte already waiting: start bit follows with no idle gap.
                            shift   <= fifo_mem[rptr];
                            state   <= S_START;
                            tx      <= 1'b0;
                            bit_cnt <= div_m1;
                        end else begin
                            state   <= S_IDLE;
                            bit_cnt <= 16'd0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Readback is purely combinational with no side effects.
    always_comb begin
        RdData = 32'd0;
        if (Sel) begin
            case (reg_idx)
                REG_STATUS:  RdData = {24'd0, 4'(count), overflow, busy, empty, full};
                REG_BAUDDIV: RdData = {16'd0, bauddiv};
                default:     RdData = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter sitting directly downstream of the multicycle ARM core's data-memory port, in parallel with data RAM.
- Consumes the core's MemWrite/Adr/WriteData stores to a fixed address window and buffers transmit bytes in a FIFO.
- Serialises bytes as 8N1 on a single tx line.
- Supplies status and configuration readback plus a hit flag; the system read mux uses the hit flag to choose between this block and RAM for ReadData.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, window base; 16-byte aligned; matched on Adr[31:4].
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from the core; high for exactly one cycle per STR.
- Adr  in  32  byte address from the core.
- WriteData  in  32  store data from the core.
- Sel  out  1  combinational: high when Adr[31:4] == BASE_ADDR[31:4].
- RdData  out  32  combinational register readback for the current Adr; 0 when Sel is low.
- tx  out  1  serial line; idles high.
- irq  out  1  registered: high while the FIFO is empty and the FSM is IDLE (transmit done).

Behaviour:
- Register map, selected by Adr[3:2]:
  - 0 TXDATA: write pushes WriteData[7:0]; reads return 0.
  - 1 STATUS: read {24'b0, count[3:0], overflow, busy, empty, full}. A write with WriteData[3]=1 clears overflow; other written bits are ignored.
  - 2 BAUDDIV: R/W; bits [15:0] are significant; reads are zero-extended.
  - 3: reserved; reads 0, writes ignored.
- Reads are combinational and have no side effects, because the core holds Adr for several cycles.
- A write takes effect only on an edge where MemWrite=1 and Sel=1. Byte lanes are ignored.
- Reset values: tx=1, irq=1, FIFO empty (count=0), overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE, bit counter=0. Sel and RdData follow their combinational definitions.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous), FIFO contents are discarded, and the partial frame is abandoned.
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH) and a separate count of width log2(FIFO_DEPTH)+1.
  - full = (count == FIFO_DEPTH); empty = (count == 0). Pointers wrap modulo FIFO_DEPTH.
  - Push while full: byte dropped, overflow set (sticky), FIFO unchanged.
  - Push and pop on the same edge while full: the pop is processed first, the push is accepted, and count is unchanged.
  - Push and pop on the same edge while not full and not empty: count is unchanged.
- Effective divider: div_eff = max(BAUDDIV, 1). A written value of 0 behaves as 1.
- Bit period: a cycle counter counts 0..div_eff-1, so each bit lasts div_eff cycles. Each new bit reloads the counter from the current BAUDDIV; a BAUDDIV change mid-frame applies from the next bit boundary.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is not empty on an edge: pop the head into an 8-bit shift register, go to START, and drive tx=0 from that edge.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. At each bit boundary shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for one bit period. At the end, if the FIFO is not empty, pop and go directly to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- Latency: a TXDATA write accepted at edge E into an empty FIFO with the FSM in IDLE gives tx=0 from edge E+1. A full frame lasts 10*div_eff cycles.
- busy = (FSM != IDLE). The popped byte does not count in count.
- irq is updated each edge as (next FIFO empty && next state IDLE).

Test Plan:
- Reset with BAUDDIV read: pulse reset low mid-operation, then read Adr=BASE+8 -> RdData=868, STATUS=0x00000002, tx=1, irq=1.
- Single frame: write BAUDDIV=4, then TXDATA=0x55 at edge E -> tx low on cycles E+1..E+4, then the LSB-first pattern 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; irq rises at E+41.
- FIFO fill and overflow: BAUDDIV=100; write 10 bytes 0x01..0x0A back to back (one per store) -> first byte popped, count=8, full=1, overflow=1. Frames carry 0x01..0x09; 0x0A is lost. Write STATUS=0x8 -> overflow=0.
- Back-to-back frames: BAUDDIV=2; write 0xA5 then 0x3C -> 40 consecutive cycles of frame data with no idle gap between the STOP bit and the next START bit.
- Divider edge and mid-frame change: BAUDDIV=0 gives 1-cycle bits (10-cycle frame). Changing BAUDDIV from 3 to 5 during DATA bit 2 -> bit 2 keeps 3 cycles and bits 3..STOP last 5 cycles.
- Decode isolation: MemWrite=1 at Adr=BASE+0x10 or 0x0000_0040 -> Sel=0, no push, RdData=0. Reads of BASE+0 and BASE+0xC return 0. Repeated reads of STATUS leave state unchanged.
